ps2_wasd_decoder: RTL and testbench

- Receives PS/2 keyboard frames and decodes Set-2 make/break codes into held-key levels.
- Drives the active-low `w`, `a`, `s`, `d` inputs of the player movement controller.
- Lives in the top level between the keyboard pins and player control, replacing the push-buttons.
- Per-key level is 0 while the key is held and 1 when released.

---
 rtl/ps2_wasd_if.sv | 24 ++
 rtl/ps2_wasd_decoder.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_wasd_decoder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_wasd_if.sv
// PS/2 pin pair plus decoded WASD levels and received-byte reporting.
interface ps2_wasd_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       w;
    logic       a;
    logic       s;
    logic       d;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    // Keyboard / pin side: drives the raw lines, observes the decoded results.
    modport master (
        output ps2_clk, ps2_data,
        input  w, a, s, d, scan_code, scan_valid, frame_err
    );

    // Decoder side.
    modport slave (
        input  ps2_clk, ps2_data,
        output w, a, s, d, scan_code, scan_valid, frame_err
    );
endinterface

// File: rtl/ps2_wasd_decoder.sv
// PS/2 Set-2 receiver that turns W/A/S/D make/break codes into active-low
// held-key levels for the player movement controller.
// Optional macro ARROW_KEYS_EN: arrow keys (E0-prefixed) also drive w/a/s/d.
module ps2_wasd_decoder #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic      clk,
    input  logic      reset,
    ps2_wasd_if.slave bus
);
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BCW = 3;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]     clk_sync;
    logic [1:0]     data_sync;
    logic           clk_filt;
    logic [FCW-1:0] flt_cnt;
    logic           fall_c;
    logic           data_bit_c;

    state_t         state, state_d;
    logic [BCW-1:0] bit_cnt, bit_cnt_d;
    logic [7:0]     shift, shift_d;
    logic           par_ok, par_ok_d;
    logic [WDW-1:0] wd, wd_d;
    logic           good_c, err_c;

    logic [7:0]     scan_code_q;
    logic           scan_valid_q;
    logic           frame_err_q;

    logic           brk, brk_d;
    logic           ext, ext_d;
    logic [3:0]     wasd, wasd_d;      // pressed bits: [0]=W [1]=A [2]=S [3]=D
    logic [3:0]     arrow, arrow_d;    // pressed bits: [0]=up [1]=left [2]=down [3]=right
    logic [3:0]     held_c;
    logic           w_q, a_q, s_q, d_q;

    // Two-stage synchronizers for the asynchronous PS/2 lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            data_sync <= {data_sync[0], bus.ps2_data};
        end
    end

    // Glitch filter: flip only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
        end else if (clk_sync[1] != clk_filt) begin
            if (flt_cnt == FCW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + FCW'(1);
            end
        end else begin
            flt_cnt <= '0;
        end
    end

    // The fall event is the cycle in which the filter commits a 1->0 flip.
    assign fall_c     = clk_filt & ~clk_sync[1] & (flt_cnt == FCW'(FILTER_LEN - 1));
    assign data_bit_c = data_sync[1];

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_ok  <= 1'b0;
            wd      <= '0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            shift   <= shift_d;
            par_ok  <= par_ok_d;
            wd      <= wd_d;
        end
    end

    // Receiver next state, frame checks and inactivity watchdog.
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        par_ok_d  = par_ok;
        wd_d      = (state == IDLE || fall_c) ? '0 : wd + WDW'(1);
        good_c    = 1'b0;
        err_c     = 1'b0;
        case (state)
            IDLE: begin
                // A fall with data high is a line glitch, not a start bit.
                if (fall_c && !data_bit_c) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall_c) begin
                    shift_d   = {data_bit_c, shift[7:1]};
                    bit_cnt_d = bit_cnt + BCW'(1);
                    if (bit_cnt == BCW'(7)) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall_c) begin
                    par_ok_d = ^{shift, data_bit_c};
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall_c) begin
                    state_d = IDLE;
                    if (data_bit_c && par_ok) good_c = 1'b1;
                    else                      err_c  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abandon a stalled frame.
        if (state != IDLE && !fall_c && wd == WDW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            wd_d    = '0;
            err_c   = 1'b1;
        end
    end

    // Registered byte report and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_code_q  <= 8'h00;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            scan_valid_q <= good_c;
            frame_err_q  <= err_c;
            if (good_c) scan_code_q <= shift;
        end
    end

    // Make/break decoding of each reported byte; errors drop pending prefixes.
    always_comb begin
        brk_d   = brk;
        ext_d   = ext;
        wasd_d  = wasd;
        arrow_d = arrow;
        if (frame_err_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (scan_valid_q) begin
            if (scan_code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (scan_code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                if (!ext) begin
                    case (scan_code_q)
                        8'h1D:   wasd_d[0] = !brk;
                        8'h1C:   wasd_d[1] = !brk;
                        8'h1B:   wasd_d[2] = !brk;
                        8'h23:   wasd_d[3] = !brk;
                        default: ;
                    endcase
                end
`ifdef ARROW_KEYS_EN
                else begin
                    case (scan_code_q)
                        8'h75:   arrow_d[0] = !brk;
                        8'h6B:   arrow_d[1] = !brk;
                        8'h72:   arrow_d[2] = !brk;
                        8'h74:   arrow_d[3] = !brk;
                        default: ;
                    endcase
                end
`endif
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end
        held_c = wasd_d | arrow_d;
    end

    // Decoder flags, pressed bits and the active-low key levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            brk   <= 1'b0;
            ext   <= 1'b0;
            wasd  <= '0;
            arrow <= '0;
            w_q   <= 1'b1;
            a_q   <= 1'b1;
            s_q   <= 1'b1;
            d_q   <= 1'b1;
        end else begin
            brk   <= brk_d;
            ext   <= ext_d;
            wasd  <= wasd_d;
            arrow <= arrow_d;
            w_q   <= ~held_c[0];
            a_q   <= ~held_c[1];
            s_q   <= ~held_c[2];
            d_q   <= ~held_c[3];
        end
    end

    assign bus.w          = w_q;
    assign bus.a          = a_q;
    assign bus.s          = s_q;
    assign bus.d          = d_q;
    assign bus.scan_code  = scan_code_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_wasd_decoder.sv
// Directed bench for ps2_wasd_decoder: bit-banged PS/2 frames, an event-level
// key model checked every cycle, plus literal key/scan_code expectations.
module tb_ps2_wasd_decoder;
    localparam int unsigned FLT  = 8;
    localparam int unsigned TO   = 3000;
    localparam int unsigned HALF = 20;
    localparam int          ERR  = -1;

    logic clk = 1'b0;
    logic reset;

    ps2_wasd_if bus ();

    ps2_wasd_decoder #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected event list: byte value, or ERR for a frame error pulse.
    int exp_arr [0:255];
    int wr_idx = 0;
    int rd_idx = 0;
    int ev_c;

    // Model of held keys: index 0..3 = W/A/S/D (arrows map onto the same slots).
    bit [3:0] m_p, m_arr, n_p, n_arr;
    bit       m_brk, m_ext, n_brk, n_ext, pend;

    function automatic int wasd_slot(input int code);
        case (code)
            'h1D:    return 0;
            'h1C:    return 1;
            'h1B:    return 2;
            'h23:    return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int arrow_slot(input int code);
        case (code)
            'h75:    return 0;
            'h6B:    return 1;
            'h72:    return 2;
            'h74:    return 3;
            default: return -1;
        endcase
    endfunction

    // Expected {w,a,s,d}: a key reads 0 while its slot is held by either source.
    function automatic logic [3:0] exp_keys();
        bit [3:0] h;
        h = m_p | m_arr;
        return {~h[0], ~h[1], ~h[2], ~h[3]};
    endfunction

    task automatic apply_ev(input int ev);
        int k;
        n_p = m_p; n_arr = m_arr; n_brk = m_brk; n_ext = m_ext;
        if (ev == ERR) begin
            n_brk = 0; n_ext = 0;
        end else if (ev == 'hF0) begin
            n_brk = 1;
        end else if (ev == 'hE0) begin
            n_ext = 1;
        end else begin
            if (!m_ext) begin
                k = wasd_slot(ev);
                if (k >= 0) n_p[k] = !m_brk;
            end else begin
`ifdef ARROW_KEYS_EN
                k = arrow_slot(ev);
                if (k >= 0) n_arr[k] = !m_brk;
`endif
            end
            n_brk = 0; n_ext = 0;
        end
        pend = 1;
    endtask

    // Per-cycle compare against the model and the expected event list.
    always @(negedge clk) begin
        if (reset) begin
            m_p = '0; m_arr = '0; m_brk = 0; m_ext = 0; pend = 0;
            rd_idx = wr_idx;
        end else begin
            if (pend) begin
                m_p = n_p; m_arr = n_arr; m_brk = n_brk; m_ext = n_ext; pend = 0;
            end
            total++;
            if ({bus.w, bus.a, bus.s, bus.d} !== exp_keys()) begin
                bad++;
                $display("FAIL keys_model got=%b want=%b t=%0t",
                         {bus.w, bus.a, bus.s, bus.d}, exp_keys(), $time);
            end
            if (bus.scan_valid === 1'b1) begin
                total++;
                if (rd_idx == wr_idx) begin
                    bad++;
                    $display("FAIL unexpected_scan_valid got=%h want=none t=%0t", bus.scan_code, $time);
                end else begin
                    ev_c = exp_arr[rd_idx];
                    rd_idx++;
                    if (ev_c == ERR || bus.scan_code !== ev_c[7:0]) begin
                        bad++;
                        $display("FAIL scan_code got=%h want=%0d(-1=err) t=%0t", bus.scan_code, ev_c, $time);
                    end
                    apply_ev(ev_c);
                end
            end
            if (bus.frame_err === 1'b1) begin
                total++;
                if (rd_idx == wr_idx) begin
                    bad++;
                    $display("FAIL unexpected_frame_err got=1 want=0 t=%0t", $time);
                end else begin
                    ev_c = exp_arr[rd_idx];
                    rd_idx++;
                    if (ev_c != ERR) begin
                        bad++;
                        $display("FAIL frame_err got=err want=byte %h t=%0t", ev_c, $time);
                    end
                    apply_ev(ERR);
                end
            end
        end
    end

    task automatic push(input int ev);
        exp_arr[wr_idx] = ev;
        wr_idx++;
    endtask

    task automatic check_lit(input string nm, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        for (int i = 0; i < budget && rd_idx != wr_idx; i++) @(posedge clk);
        total++;
        if (rd_idx != wr_idx) begin
            bad++;
            $display("FAIL %s_drain got=%0d pending want=0", nm, wr_idx - rd_idx);
        end
        settle();
    endtask

    // One PS/2 bit: data set while clock is high, then a low pulse.
    task automatic ps2_fall(input logic b);
        bus.ps2_data = b;
        repeat (HALF) @(posedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string nm);
        logic [10:0] f;
        f = mk_frame(b, bad_par, bad_stop);
        push((bad_par || bad_stop) ? ERR : int'(b));
        for (int i = 0; i < 11; i++) ps2_fall(f[i]);
        bus.ps2_data = 1'b1;
        wait_drain(nm, 400);
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        logic [10:0] f;
        f = mk_frame(b, 0, 0);
        for (int i = 0; i < n; i++) ps2_fall(f[i]);
        bus.ps2_data = 1'b1;
    endtask

    function automatic logic [7:0] keys();
        return {4'h0, bus.w, bus.a, bus.s, bus.d};
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_lit("rst_keys", keys(), 8'h0F);
        check_lit("rst_code", bus.scan_code, 8'h00);
        check_lit("rst_pulses", {6'd0, bus.scan_valid, bus.frame_err}, 8'h00);

        send(8'hF0, 0, 0, "brk_unpressed_f0");
        send(8'h1B, 0, 0, "brk_unpressed_1b");
        check_lit("brk_unpressed_keys", keys(), 8'h0F);

        send(8'h1D, 0, 0, "make_w");
        check_lit("make_w_keys", keys(), 8'h07);
        check_lit("make_w_code", bus.scan_code, 8'h1D);
        send(8'h1D, 0, 0, "repeat_w");
        check_lit("repeat_w_keys", keys(), 8'h07);
        send(8'hF0, 0, 0, "rel_w_f0");
        send(8'h1D, 0, 0, "rel_w_1d");
        check_lit("rel_w_keys", keys(), 8'h0F);

        send(8'h1C, 0, 0, "make_a");
        send(8'h23, 0, 0, "make_d");
        check_lit("a_and_d_keys", keys(), 8'h0A);
        send(8'hF0, 0, 0, "rel_a_f0");
        send(8'h1C, 0, 0, "rel_a_1c");
        check_lit("rel_a_keys", keys(), 8'h0E);

        send(8'h1B, 1, 0, "bad_parity");
        check_lit("bad_parity_keys", keys(), 8'h0E);
        check_lit("bad_parity_code", bus.scan_code, 8'h1C);
        send(8'hF0, 0, 0, "f0_before_err");
        send(8'h1B, 0, 1, "bad_stop");
        send(8'h1B, 0, 0, "make_s_after_err");
        check_lit("make_s_keys", keys(), 8'h0C);

        send(8'hF0, 0, 0, "rel_d_f0");
        send(8'h23, 0, 0, "rel_d_23");
        check_lit("rel_d_keys", keys(), 8'h0D);
        send(8'hF0, 0, 0, "f0_before_timeout");
        push(ERR);
        send_partial(8'h23, 5);
        wait_drain("timeout", TO + 400);
        send(8'h23, 0, 0, "make_d_after_timeout");
        check_lit("timeout_keys", keys(), 8'h0C);

        ps2_fall(1'b1);
        settle();
        check_lit("glitch_keys", keys(), 8'h0C);

        send_partial(8'h1D, 3);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (TO + 200) @(posedge clk);
        @(negedge clk);
        check_lit("midreset_keys", keys(), 8'h0F);
        check_lit("midreset_code", bus.scan_code, 8'h00);

        send(8'hE0, 0, 0, "ext_up_e0");
        send(8'h75, 0, 0, "ext_up_75");
        check_lit("ext_up_code", bus.scan_code, 8'h75);
`ifdef ARROW_KEYS_EN
        check_lit("ext_up_keys", keys(), 8'h07);
`else
        check_lit("ext_up_keys", keys(), 8'h0F);
`endif
        send(8'hE0, 0, 0, "ext_rel_e0");
        send(8'hF0, 0, 0, "ext_rel_f0");
        send(8'h75, 0, 0, "ext_rel_75");
        check_lit("ext_rel_keys", keys(), 8'h0F);

        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
